// File: rtl/m_ledpwm_defs.sv
// Shared register indices and limits for the LED PWM block; firmware headers mirror these values.
package m_ledpwm_defs;

    typedef enum logic [3:0] {
        REG_CTRL   = 4'd0,
        REG_STATIC = 4'd1,
        REG_MODE   = 4'd2,
        REG_DUTY0  = 4'd3
    } reg_idx_e;

    localparam int NCH_MAX        = 12;
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;

    function automatic logic [3:0] duty_index(input int k);
        return 4'(REG_DUTY0) + 4'(k);
    endfunction

endpackage

// File: rtl/m_ledpwm_ch.sv
// One LED channel: programmed duty, active duty, compare and registered drive.
// With LEDPWM_SHADOW_EN the active duty is a shadow copy refreshed at period start or while disabled.
module m_ledpwm_ch
    import m_ledpwm_defs::*;
#(
    parameter int PWMW = 8
) (
    input  logic            CLK_I,
    input  logic            nRST_I,
    input  logic            i_en,
    input  logic            i_mode,
    input  logic            i_static,
    input  logic            i_wr,
    input  logic [PWMW-1:0] i_wdata,
    input  logic            i_pstart,
    input  logic [PWMW-1:0] i_cnt,
    output logic [PWMW-1:0] o_prog,
    output logic            o_led
);

    logic [PWMW-1:0] r_prog;
    logic [PWMW-1:0] w_active;
    logic            w_led_nxt;
    logic            r_led;

    // Programmed duty as last written by software
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_prog <= {PWMW{1'b0}};
        end else if (i_wr) begin
            r_prog <= i_wdata;
        end else begin
            r_prog <= r_prog;
        end
    end

`ifdef LEDPWM_SHADOW_EN
    logic [PWMW-1:0] r_active;

    // Shadow load; a write landing on the period-start tick wins over the old value
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_active <= {PWMW{1'b0}};
        end else if (!i_en || i_pstart) begin
            r_active <= i_wr ? i_wdata : r_prog;
        end else begin
            r_active <= r_active;
        end
    end

    assign w_active = r_active;
`else
    logic w_unused;

    assign w_unused = i_pstart;
    assign w_active = r_prog;
`endif

    // PWM compare or static level
    always_comb begin
        w_led_nxt = 1'b0;
        if (i_en && i_mode) begin
            w_led_nxt = (i_cnt < w_active);
        end else begin
            w_led_nxt = i_static;
        end
    end

    // Output register
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign o_prog = r_prog;
    assign o_led  = r_led;

endmodule

// File: rtl/m_ledpwm.sv
// Wishbone-mapped LED PWM controller: prescaler, shared PWM counter and NCH channels.
// Build option LEDPWM_SHADOW_EN: duty updates are deferred to the next period start.
module m_ledpwm
    import m_ledpwm_defs::*;
#(
    parameter int NCH    = 4,
    parameter int PWMW   = 8,
    parameter int PRESCW = 8
) (
    input  logic            CLK_I,
    input  logic            nRST_I,
    input  logic            STB_I,
    input  logic            WE_I,
    input  logic [3:0]      ADR_I,
    input  logic [31:0]     DAT_I,
    output logic [31:0]     DAT_O,
    output logic            ACK_O,
    output logic [NCH-1:0]  led_o
);

    localparam logic [PWMW-1:0]   CNT_ONE   = {{(PWMW-1){1'b0}}, 1'b1};
    localparam logic [PRESCW-1:0] PRESC_ONE = {{(PRESCW-1){1'b0}}, 1'b1};

    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("m_ledpwm: NCH out of range");
    end

    logic              r_en;
    logic [PRESCW-1:0] r_presc;
    logic [NCH-1:0]    r_static;
    logic [NCH-1:0]    r_mode;
    logic [PRESCW-1:0] r_presc_cnt;
    logic [PWMW-1:0]   r_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;

    logic              w_access;
    logic              w_wr;
    logic              w_tick;
    logic              w_pstart;
    logic [NCH-1:0]    w_duty_sel;
    logic [NCH-1:0]    w_duty_wr;
    logic [PWMW-1:0]   w_prog [NCH];
    logic [31:0]       w_rdata;
    logic              w_unused;

    // The first strobe cycle of an access is the only one that commits
    assign w_access = STB_I & ~r_ack;
    assign w_wr     = w_access & WE_I;
    assign w_tick   = r_en & (r_presc_cnt == {PRESCW{1'b0}});
    assign w_pstart = w_tick & (&r_cnt);
    assign w_unused = ^DAT_I;

    // Control, static and mode registers
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_en     <= 1'b0;
            r_presc  <= {PRESCW{1'b0}};
            r_static <= {NCH{1'b0}};
            r_mode   <= {NCH{1'b0}};
        end else if (w_wr) begin
            case (ADR_I)
                REG_CTRL: begin
                    r_en    <= DAT_I[CTRL_EN_BIT];
                    r_presc <= DAT_I[CTRL_PRESC_LSB +: PRESCW];
                end
                REG_STATIC: r_static <= DAT_I[NCH-1:0];
                REG_MODE:   r_mode   <= DAT_I[NCH-1:0];
                default: begin
                    r_en <= r_en;
                end
            endcase
        end else begin
            r_en <= r_en;
        end
    end

    // Prescaler and PWM counter; both parked at zero while disabled
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_presc_cnt <= {PRESCW{1'b0}};
            r_cnt       <= {PWMW{1'b0}};
        end else if (!r_en) begin
            r_presc_cnt <= {PRESCW{1'b0}};
            r_cnt       <= {PWMW{1'b0}};
        end else if (w_tick) begin
            r_presc_cnt <= r_presc;
            r_cnt       <= r_cnt + CNT_ONE;
        end else begin
            r_presc_cnt <= r_presc_cnt - PRESC_ONE;
            r_cnt       <= r_cnt;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_duty_sel[k] = (ADR_I == duty_index(k));
        assign w_duty_wr[k]  = w_wr & w_duty_sel[k];

        m_ledpwm_ch #(
            .PWMW(PWMW)
        ) u_ch (
            .CLK_I    (CLK_I),
            .nRST_I   (nRST_I),
            .i_en     (r_en),
            .i_mode   (r_mode[k]),
            .i_static (r_static[k]),
            .i_wr     (w_duty_wr[k]),
            .i_wdata  (DAT_I[PWMW-1:0]),
            .i_pstart (w_pstart),
            .i_cnt    (r_cnt),
            .o_prog   (w_prog[k]),
            .o_led    (led_o[k])
        );
    end

    // Read mux; unmapped indices fall through to zero
    always_comb begin
        w_rdata = 32'd0;
        case (ADR_I)
            REG_CTRL: begin
                w_rdata[CTRL_EN_BIT]               = r_en;
                w_rdata[CTRL_PRESC_LSB +: PRESCW]  = r_presc;
            end
            REG_STATIC: w_rdata[NCH-1:0] = r_static;
            REG_MODE:   w_rdata[NCH-1:0] = r_mode;
            default: begin
                for (int k = 0; k < NCH; k++) begin
                    w_rdata = w_rdata | ({32{w_duty_sel[k]}} & 32'(w_prog[k]));
                end
            end
        endcase
    end

    // Bus handshake: one wait state, single-cycle acknowledge
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_access ? w_rdata : 32'd0;
        end
    end

    assign ACK_O = r_ack;
    assign DAT_O = r_dat;

endmodule

// File: tb/tb_m_ledpwm.sv
// Self-checking bench for m_ledpwm: register table, bus timing, reset, PWM shape and random duty sweeps.
module tb_m_ledpwm;

    localparam int NCH    = 4;
    localparam int PWMW   = 8;
    localparam int PRESCW = 8;

    logic            clk  = 1'b0;
    logic            nrst = 1'b0;
    logic            stb  = 1'b0;
    logic            we   = 1'b0;
    logic [3:0]      adr  = 4'd0;
    logic [31:0]     dat  = 32'd0;
    logic [31:0]     dat_o;
    logic            ack;
    logic [NCH-1:0]  led;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int hi_cnt [NCH];

    typedef struct {
        logic [3:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    m_ledpwm #(.NCH(NCH), .PWMW(PWMW), .PRESCW(PRESCW)) dut (
        .CLK_I  (clk),
        .nRST_I (nrst),
        .STB_I  (stb),
        .WE_I   (we),
        .ADR_I  (adr),
        .DAT_I  (dat),
        .DAT_O  (dat_o),
        .ACK_O  (ack),
        .led_o  (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        bit got;
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = a; dat = d;
        wait_ack(got);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        bit got;
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = a;
        wait_ack(got);
        d = dat_o;
        stb = 1'b0;
    endtask

    // Counts high samples per channel over n consecutive negedges, starting with the current one
    task automatic count_all(input int n);
        for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            for (int k = 0; k < NCH; k++) hi_cnt[k] += int'(led[k]);
        end
    endtask

    task automatic find_rise(input int ch, output int t);
        logic prev;
        bit   found;
        found = 1'b0;
        t     = -1;
        prev  = led[ch];
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!prev && led[ch]) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
            prev = led[ch];
        end
        check("rise_found", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int t1, t2;
        int p, w;
        logic [PWMW-1:0] duty [NCH];
        logic [NCH-1:0]  mode, stat;
        int exp_hi;

        tbl[0] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_FF01};
        tbl[1] = '{4'd1,  32'hFFFF_FFF5, 32'h0000_0005};
        tbl[2] = '{4'd2,  32'h0000_00F3, 32'h0000_0003};
        tbl[3] = '{4'd3,  32'h0000_1234, 32'h0000_0034};
        tbl[4] = '{4'd4,  32'hFFFF_FF80, 32'h0000_0080};
        tbl[5] = '{4'd6,  32'h0000_ABCD, 32'h0000_00CD};
        tbl[6] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset state
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_led", {28'd0, led}, 32'd0);
        nrst = 1'b1;

        // Register map write/read-back
        for (int i = 0; i < 8; i++) begin
            bus_wr(tbl[i].adr, tbl[i].wdata);
            bus_rd(tbl[i].adr, rd);
            check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        for (int i = 0; i < 8; i++) begin
            bus_rd(tbl[i].adr, rd);
            check($sformatf("tbl_reread%0d", i), rd, tbl[i].exp);
        end

        // Reset in the middle of an access
        bus_wr(4'd2, 32'd0);
        bus_wr(4'd1, 32'hF);
        repeat (2) @(negedge clk);
        check("pre_rst_led", {28'd0, led}, 32'hF);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = 4'd1; dat = 32'h3;
        #2 nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("in_rst_ack", {31'd0, ack}, 32'd0);
            check("in_rst_dat", dat_o, 32'd0);
            check("in_rst_led", {28'd0, led}, 32'd0);
        end
        stb = 1'b0; we = 1'b0;
        nrst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_rd(4'(a), rd);
            check($sformatf("post_rst_reg%0d", a), rd, 32'd0);
        end
        check("post_rst_led", {28'd0, led}, 32'd0);

        // Bus timing on a CTRL write
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = 4'd0; dat = 32'h0000_0301;
        check("bt_ack_before", {31'd0, ack}, 32'd0);
        @(negedge clk);
        check("bt_ack_one", {31'd0, ack}, 32'd1);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("bt_ack_after", {31'd0, ack}, 32'd0);
        check("bt_dat_idle", dat_o, 32'd0);
        bus_rd(4'd0, rd);
        check("bt_readback", rd, 32'h0000_0301);

        // Held strobe gives alternating ACK, never back-to-back
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("held_ack%0d", i), {31'd0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        stb = 1'b0;

        // PWM shape at DUTY0=64
        bus_wr(4'd0, 32'd0);
        bus_wr(4'd3, 32'd64);
        bus_wr(4'd2, 32'd1);
        bus_wr(4'd1, 32'd0);
        bus_wr(4'd0, 32'd1);
        find_rise(0, t1);
        count_all(256);
        check("pwm64_high", 32'(hi_cnt[0]), 32'd64);
        find_rise(0, t2);
        check("pwm64_period", 32'(t2 - t1), 32'd256);

        // Duty boundaries
        bus_wr(4'd3, 32'd0);
        repeat (300) @(negedge clk);
        count_all(256);
        check("duty0_high", 32'(hi_cnt[0]), 32'd0);
        bus_wr(4'd3, 32'd255);
        repeat (300) @(negedge clk);
        count_all(256);
        check("duty255_high", 32'(hi_cnt[0]), 32'd255);

        // Duty change mid-period
        bus_wr(4'd3, 32'd64);
        repeat (300) @(negedge clk);
        find_rise(0, t1);
        fork
            count_all(256);
            begin
                repeat (9) @(negedge clk);
                bus_wr(4'd3, 32'd128);
            end
        join
`ifdef LEDPWM_SHADOW_EN
        check("chg_cur_period", 32'(hi_cnt[0]), 32'd64);
`else
        check("chg_cur_period", 32'(hi_cnt[0]), 32'd128);
`endif
        @(negedge clk);
        count_all(256);
        check("chg_next_period", 32'(hi_cnt[0]), 32'd128);

        // Static drive and disable
        bus_wr(4'd2, 32'd0);
        bus_wr(4'd1, 32'hA);
        repeat (3) @(negedge clk);
        check("static_led", {28'd0, led}, 32'hA);
        for (int k = 0; k < NCH; k++) bus_wr(4'(3 + k), 32'd255);
        bus_wr(4'd2, 32'hF);
        repeat (300) @(negedge clk);
        bus_wr(4'd0, 32'd0);
        @(negedge clk);
        check("disable_led", {28'd0, led}, 32'hA);
        bus_wr(4'd3, 32'd64);
        bus_wr(4'd0, 32'd1);
        @(negedge clk);
        count_all(64);
        check("restart_high", 32'(hi_cnt[0]), 32'd64);
        @(negedge clk);
        check("restart_low", {31'd0, led[0]}, 32'd0);

        // Random duty/mode/static/prescaler sweeps
        for (int it = 0; it < 3; it++) begin
            p    = $urandom_range(0, 3);
            w    = 256 * (p + 1);
            mode = 4'($urandom_range(0, 15));
            stat = 4'($urandom_range(0, 15));
            bus_wr(4'd0, 32'd0);
            for (int k = 0; k < NCH; k++) begin
                duty[k] = 8'($urandom_range(0, 255));
                bus_wr(4'(3 + k), 32'(duty[k]));
            end
            bus_wr(4'd2, 32'(mode));
            bus_wr(4'd1, 32'(stat));
            bus_wr(4'd0, (32'(p) << 8) | 32'd1);
            repeat (300 * (p + 1) + 5) @(negedge clk);
            count_all(w);
            for (int k = 0; k < NCH; k++) begin
                exp_hi = mode[k] ? int'(duty[k]) * (p + 1) : (stat[k] ? w : 0);
                check($sformatf("rnd%0d_ch%0d", it, k), 32'(hi_cnt[k]), 32'(exp_hi));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/m_ledpwm.md
M_LEDPWM -- requirements
Module: m_ledpwm

Interface
REQ-001 SHALL have parameter NCH, default 4: number of LED channels, legal 1..12.
REQ-002 SHALL have parameter PWMW, default 8: duty and PWM counter width, legal 2..16.
REQ-003 SHALL have parameter PRESCW, default 8: prescaler width, legal 1..16.
REQ-004 SHALL have port CLK_I, input, 1: system clock, all state on rising edge.
REQ-005 SHALL have port nRST_I, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port STB_I, input, 1: Wishbone strobe, already address-decoded by the top level.
REQ-007 SHALL have port WE_I, input, 1: write enable.
REQ-008 SHALL have port ADR_I, input, 4: word index, bits [5:2] of the byte address.
REQ-009 SHALL have port DAT_I, input, 32: write data.
REQ-010 SHALL have port DAT_O, output, 32: read data, zero-extended.
REQ-011 SHALL have port ACK_O, output, 1: Wishbone acknowledge.
REQ-012 SHALL have port led_o, output, NCH: registered LED drive, active-high.

Function
REQ-013 SHALL decode the register map as follows; unmapped indices read 0 and ignore writes.
- 0 CTRL: bit0 EN; bits [8+PRESCW-1:8] PRESC.
- 1 STATIC[NCH-1:0].
- 2 MODE[NCH-1:0].
- 3+k DUTY_k[PWMW-1:0], for k<NCH.
REQ-014 SHALL commit a write in the first STB_I cycle (STB_I & ~ACK_O).
REQ-015 SHALL register ACK_O as STB_I & ~ACK_O: one wait state, single-cycle ACK, no back-to-back ACK.
REQ-016 SHALL register DAT_O in the same cycle; it is valid while ACK_O=1 and 0 otherwise.
REQ-017 SHALL return the programmed value on DUTY reads, not the active value.
REQ-018 SHALL run the prescaler only while EN=1.
- Prescaler counts down from PRESC to 0.
- At 0 it issues a one-cycle tick and reloads PRESC.
- PRESC=0 gives a tick every cycle.
- A PRESC write takes effect at the next reload.
REQ-019 SHALL advance the PWM counter cnt by 1 on each tick, wrapping 2^PWMW-1 to 0; the wrap tick is "period start".
REQ-020 SHALL compute channel k as follows, with led_o registered one cycle after cnt changes:
- EN=1 and MODE[k]=1: cnt < DUTY_active_k.
- otherwise: STATIC[k].
REQ-021 SHALL make DUTY=0 give constant off, and DUTY=2^PWMW-1 give on for all but one count per period.
REQ-022 SHALL, when EN goes 1 to 0, clear the prescaler and cnt to 0 in the next cycle, and led_o SHALL follow STATIC.
REQ-023 SHALL, on a DUTY_k write coinciding with period start, let the write win and apply it from the next period (shadow mode).

Reset
REQ-024 SHALL, while nRST_I=0, asynchronously force all of the following to 0: CTRL, STATIC, MODE, all DUTY (programmed and active), prescaler, cnt, led_o, ACK_O and DAT_O.
REQ-025 SHALL abort any access in progress when reset is asserted, with no ACK issued.

Configuration
REQ-026 SHALL, with macro LEDPWM_SHADOW_EN defined, copy programmed DUTY_k to active DUTY_k only at period start, or immediately while EN=0.
REQ-027 SHALL, without LEDPWM_SHADOW_EN, use programmed DUTY_k directly as active, effective from the cycle after the write; there is no shadow storage.

Structure
REQ-028 SHALL take the register indices (CTRL=0, STATIC=1, MODE=2, DUTY0=3) and the NCH upper bound of 12 from a shared definitions package m_ledpwm_defs, also used by firmware headers.
REQ-029 SHALL instantiate sub-module m_ledpwm_ch NCH times; each instance holds the programmed and active duty, the compare and the output register.

Verification
REQ-030 SHALL cover reset: pulse nRST_I low mid-access, then read all registers -> all read 0, led_o=0, no ACK during reset.
REQ-031 SHALL cover bus timing: write CTRL=0x0000_0301 -> ACK_O exactly one cycle after STB_I, then low; read back returns 0x301.
REQ-032 SHALL cover PWM: EN=1, PRESC=0, MODE=0x1, DUTY0=64 (PWMW=8) -> led_o[0] high for 64 of every 256 cycles, period 256.
REQ-033 SHALL cover duty boundaries: DUTY0=0 -> led_o[0] never high; DUTY0=255 -> exactly one low cycle per 256.
REQ-034 SHALL cover shadowing with LEDPWM_SHADOW_EN: change DUTY0 from 64 to 128 at cnt=10 -> current period keeps 64, next period shows 128; without the macro -> 128 applies from cnt=11.
REQ-035 SHALL cover static and disable: MODE=0, STATIC=0xA -> led_o=0xA; with MODE=0xF, clearing EN -> led_o=STATIC in the next cycle and cnt=0.
